// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and default widths/limits.
package mips_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned DEF_MAX_WAIT   = 15;
    localparam int unsigned WAIT_CNT_W     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the MEM stage; expire flags the last permitted wait cycle.
module mem_wait_timer
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  expire
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign expire = (count == WAIT_CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_stage.sv
// MEM stage with data-memory handshake, wait-state timeout and MEM/WB register.
// Optional: define MEM_ALIGN_CHECK_EN to squash word-misaligned accesses.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteIn,
    input  logic                  MemReadIn,
    input  logic                  MemWriteIn,
    input  logic [DATA_W-1:0]     ALUResultIn,
    input  logic [DATA_W-1:0]     storeValIn,
    input  logic [REG_ADDR_W-1:0] regWriteAddressIn,
    output logic [DATA_W-1:0]     memAddr,
    output logic [DATA_W-1:0]     memWData,
    output logic                  memRead,
    output logic                  memWrite,
    input  logic [DATA_W-1:0]     memRData,
    input  logic                  memReady,
    output logic                  stall,
    output logic                  RegWrite,
    output logic [DATA_W-1:0]     writeData,
    output logic [REG_ADDR_W-1:0] regWriteAddress,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  misaligned,
`endif
    output logic                  memError
);

    mem_state_t            state;
    logic                  is_mem;
    logic                  is_load;
    logic                  is_store;
    logic                  mis;
    logic                  mem_active;
    logic                  mem_done;
    logic                  abort;
    logic                  timer_clear;
    logic                  timer_inc;
    logic                  expire;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .count  (wait_cnt),
        .expire (expire)
    );

    // Decode, memory port and handshake control; a write wins over a read.
    always_comb begin
        is_mem   = MemReadIn | MemWriteIn;
        is_store = MemWriteIn;
        is_load  = MemReadIn & ~MemWriteIn;
        mis      = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis      = is_mem & (ALUResultIn[1:0] != 2'b00);
`endif
        mem_active = is_mem & ~mis;

        memAddr  = ALUResultIn;
        memWData = storeValIn;
        memRead  = ~reset & is_load & ~mis;
        memWrite = ~reset & is_store & ~mis;

        stall       = 1'b0;
        abort       = 1'b0;
        mem_done    = 1'b0;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;

        if (!reset) begin
            case (state)
                IDLE: begin
                    if (mem_active) begin
                        if (memReady) begin
                            mem_done = 1'b1;
                        end else begin
                            stall     = 1'b1;
                            timer_inc = 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (memReady) begin
                        mem_done    = 1'b1;
                        timer_clear = 1'b1;
                    end else if (expire) begin
                        abort       = 1'b1;
                        timer_clear = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        timer_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state plus MEM/WB pipeline register and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            RegWrite        <= 1'b0;
            writeData       <= '0;
            regWriteAddress <= '0;
            memError        <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misaligned      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:    if (stall)  state <= WAIT;
                WAIT:    if (!stall) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (stall) begin
                RegWrite <= 1'b0;
            end else if (abort || mis) begin
                RegWrite        <= 1'b0;
                writeData       <= '0;
                regWriteAddress <= regWriteAddressIn;
            end else begin
                RegWrite        <= RegWriteIn;
                writeData       <= (is_load && mem_done) ? memRData : ALUResultIn;
                regWriteAddress <= regWriteAddressIn;
            end

            if (abort) begin
                memError <= 1'b1;
            end
`ifdef MEM_ALIGN_CHECK_EN
            misaligned <= mis;
`endif
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Consumes the EX/MEM register outputs, drives the data-memory port with a ready handshake, and stalls the front of the pipeline while memory is busy.
- Contains the MEM/WB pipeline register, so it feeds WB directly.
- Includes a wait-state timeout that aborts hung accesses.

Parameters:
- DATA_W, 32, width of data path and memory address.
- REG_ADDR_W, 5, register-file address width.
- MAX_WAIT, 15, number of WAIT cycles without memReady before the access is aborted (range 1..255).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- RegWriteIn  input  1  WB control from EX/MEM.
- MemReadIn  input  1  load request from EX/MEM.
- MemWriteIn  input  1  store request from EX/MEM.
- ALUResultIn  input  DATA_W  address, or non-memory result.
- storeValIn  input  DATA_W  store data.
- regWriteAddressIn  input  REG_ADDR_W  destination register.
- memAddr  output  DATA_W  data-memory address.
- memWData  output  DATA_W  data-memory write data.
- memRead  output  1  memory read strobe.
- memWrite  output  1  memory write strobe.
- memRData  input  DATA_W  memory read data, valid with memReady.
- memReady  input  1  memory completes the current access this cycle.
- stall  output  1  freeze PC/IF/ID/ID-EX/EX-MEM this cycle.
- RegWrite  output  1  MEM/WB: write enable to WB.
- writeData  output  DATA_W  MEM/WB: load data or ALU result.
- regWriteAddress  output  REG_ADDR_W  MEM/WB: destination register.
- memError  output  1  sticky flag: an access timed out.

Behaviour:
Clock and reset:
- Single clock clk.
- Reset is synchronous and active-high; a cycle with reset high forces all registered state to its reset value.
- Reset values: state=IDLE, waitCnt=0, RegWrite=0, writeData=0, regWriteAddress=0, memError=0.
- memRead and memWrite are gated with !reset, so a request is dropped in the same cycle reset rises, including mid-WAIT.

Access decode:
- isMem = MemReadIn | MemWriteIn.
- If both MemReadIn and MemWriteIn are set, the access is a write; the read is ignored and RegWrite takes the ALU path.

Memory port (combinational):
- memAddr = ALUResultIn, memWData = storeValIn.
- memRead/memWrite mirror the decoded op while the state is IDLE or WAIT.
- Upstream holds its inputs stable while stall is high.

FSM:
- IDLE, memory op with memReady=1: zero-wait completion; stall=0; MEM/WB loads.
- IDLE, memory op with memReady=0: stall=1; go to WAIT; waitCnt=1.
- IDLE, no memory op: stall=0; MEM/WB loads the ALU path.
- WAIT, memReady=1: complete; stall=0; go to IDLE; waitCnt=0.
- WAIT, memReady=0 and waitCnt<MAX_WAIT: stall=1; waitCnt+1.
- WAIT, memReady=0 and waitCnt==MAX_WAIT: abort.
  - Strobes stay high this cycle; stall=0.
  - MEM/WB loads RegWrite=0 and writeData=0.
  - memError set to 1 and holds until reset.
  - Go to IDLE.
- memReady is ignored in IDLE when there is no memory op.

MEM/WB register (on a non-stall cycle):
- RegWrite <= RegWriteIn, or 0 on abort.
- writeData <= memRData for a completed load, otherwise ALUResultIn.
- regWriteAddress <= regWriteAddressIn.
- During stall cycles, RegWrite <= 0 (bubble into WB); writeData and regWriteAddress hold.

Latency and throughput:
- Latency is one cycle from the EX/MEM inputs to the MEM/WB outputs for a zero-wait access, plus N for N wait cycles.
- Back-to-back memory ops each pass through IDLE; there is no idle gap when memReady=1.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: an access with ALUResultIn[1:0]!=0 is misaligned.
  - Strobes are suppressed; no stall.
  - MEM/WB loads RegWrite=0 and writeData=0.
  - Adds output misaligned (1 bit, registered): pulses high for one cycle alongside the squashed MEM/WB entry.
  - Reset value of misaligned is 0.
- Undefined: no check; port absent; low address bits are passed to memory untouched.

Decomposition:
- Shared package mips_pkg:
  - mem_state_t enum {IDLE, WAIT}.
  - DATA_W and REG_ADDR_W defaults.
  - MAX_WAIT default constant.
- Sub-module mem_wait_timer: the waitCnt counter with clear, increment and expire outputs, instantiated once.

Test Plan:
- Zero-wait load: MemReadIn=1, ALUResultIn=0x100, memReady=1, memRData=0xDEADBEEF, RegWriteIn=1, rd=8 -> next cycle RegWrite=1, writeData=0xDEADBEEF, regWriteAddress=8; stall never high.
- Store with 2 wait cycles: MemWriteIn=1, addr 0x40, storeVal 0x1234, memReady low for 2 cycles -> stall high for exactly 2 cycles; memWrite/memAddr/memWData stable for 3 cycles; RegWrite=0 during the stall.
- Timeout, MAX_WAIT=3, memReady held 0 on a load -> stall high for 3 cycles; on the 4th cycle stall=0, then RegWrite=0, writeData=0, memError=1 and sticky until reset.
- ALU pass-through back-to-back: three non-memory ops with results 1, 2, 3 -> writeData 1, 2, 3 on consecutive cycles with no stall.
- Reset mid-WAIT: reset asserted on the 2nd wait cycle -> memRead=0 that cycle; next cycle state=IDLE, all outputs 0, memError=0.
- MEM_ALIGN_CHECK_EN: load at 0x102 -> no memRead, misaligned=1 for one cycle, RegWrite=0.
